// File: rtl/bch_encode_stream_pkg.sv
// Shared BCH code parameters and elaboration-time helpers for GF(2^m) generator
// polynomial construction.
package bch_encode_stream_pkg;

  localparam int unsigned GEN_W = 128;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] t;
  } bch_param_t;

  localparam bch_param_t BCH_SANE = '{m: 8'd4, t: 8'd2};

  function automatic int unsigned bch_n(input bch_param_t p);
    return (32'd1 << p.m) - 32'd1;
  endfunction

  function automatic int unsigned bch_prim(input int unsigned m);
    case (m)
      3:       return 32'h00B;
      5:       return 32'h025;
      6:       return 32'h043;
      7:       return 32'h089;
      8:       return 32'h11D;
      9:       return 32'h211;
      10:      return 32'h409;
      default: return 32'h013;
    endcase
  endfunction

  function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b,
                                         input int unsigned m);
    int unsigned r;
    int unsigned aa;
    int unsigned prim;
    r = 0;
    aa = a;
    prim = bch_prim(m);
    for (int unsigned i = 0; i < m; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa << 1;
      if (aa[m]) aa = aa ^ prim;
    end
    return r;
  endfunction

  function automatic int unsigned gf_pow(input int unsigned e, input int unsigned m);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < e; k++) r = gf_mul(r, 32'd2, m);
    return r;
  endfunction

  // Evaluate the binary polynomial c (degree d) at field element beta
  function automatic int unsigned gf_eval(input int unsigned c, input int unsigned d,
                                          input int unsigned beta, input int unsigned m);
    int unsigned r;
    r = 0;
    for (int k = int'(d); k >= 0; k--) r = gf_mul(r, beta, m) ^ 32'(c[k]);
    return r;
  endfunction

  // Product of the distinct minimal polynomials of alpha^1 .. alpha^(2t-1)
  function automatic logic [GEN_W-1:0] bch_gen(input bch_param_t p);
    int unsigned n, m, d, e, beta, mp;
    bit dup, found;
    logic [GEN_W-1:0] g, gn;
    n = bch_n(p);
    m = 32'(p.m);
    g = GEN_W'(1);
    for (int unsigned i = 1; i < 2 * 32'(p.t); i += 2) begin
      dup = 1'b0;
      d = 1;
      e = (i * 2) % n;
      while (e != i) begin
        if (e < i) dup = 1'b1;
        e = (e * 2) % n;
        d++;
      end
      if (!dup) begin
        beta = gf_pow(i, m);
        mp = 0;
        found = 1'b0;
        for (int unsigned c = 32'd1 << d; c < (32'd2 << d); c++) begin
          if (!found && gf_eval(c, d, beta, m) == 0) begin
            mp = c;
            found = 1'b1;
          end
        end
        gn = '0;
        for (int unsigned k = 0; k <= d; k++) if (mp[k]) gn = gn ^ (g << k);
        g = gn;
      end
    end
    return g;
  endfunction

  function automatic int unsigned bch_ecc_bits(input bch_param_t p);
    logic [GEN_W-1:0] g;
    int unsigned deg;
    g = bch_gen(p);
    deg = 0;
    for (int unsigned i = 0; i < GEN_W; i++) if (g[i]) deg = i;
    return deg;
  endfunction

  function automatic int unsigned bch_data_bits(input bch_param_t p);
    return bch_n(p) - bch_ecc_bits(p);
  endfunction

endpackage

// File: rtl/bch_lfsr_step.sv
// BITS-wide step of the generator-polynomial division LFSR, MSB of data first.
module bch_lfsr_step #(
  parameter int unsigned ECC_BITS = 8,
  parameter int unsigned BITS     = 1,
  parameter logic [ECC_BITS-1:0] GEN = '0
) (
  input  logic [ECC_BITS-1:0] lfsr_in,
  input  logic [BITS-1:0]     data,
  output logic [ECC_BITS-1:0] lfsr_out
);

  logic fb;

  always_comb begin
    lfsr_out = lfsr_in;
    fb       = 1'b0;
    for (int i = int'(BITS) - 1; i >= 0; i--) begin
      fb       = data[i] ^ lfsr_out[ECC_BITS-1];
      lfsr_out = {lfsr_out[ECC_BITS-2:0], 1'b0} ^ (fb ? GEN : '0);
    end
  end

endmodule

// File: rtl/bch_encode_stream.sv
// Systematic BCH encoder: forwards message beats, then appends the LFSR parity.
module bch_encode_stream
  import bch_encode_stream_pkg::*;
#(
  parameter bch_param_t  P    = BCH_SANE,
  parameter int unsigned BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            ready,
  input  logic            data_valid,
  input  logic [BITS-1:0] data_in,
  output logic            valid,
  output logic            first,
  output logic            last,
  output logic [BITS-1:0] data_out
);

  localparam int unsigned ECC_BITS   = bch_ecc_bits(P);
  localparam int unsigned DATA_BITS  = bch_data_bits(P);
  localparam logic [GEN_W-1:0] GEN_FULL = bch_gen(P);
  localparam logic [ECC_BITS-1:0] GEN = GEN_FULL[ECC_BITS-1:0];
  localparam int unsigned DATA_BEATS = DATA_BITS / BITS;
  localparam int unsigned ECC_BEATS  = ECC_BITS / BITS;
  localparam int unsigned CNT_MAX    = (DATA_BEATS > ECC_BEATS) ? DATA_BEATS : ECC_BEATS;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  if ((DATA_BITS % BITS) != 0 || (ECC_BITS % BITS) != 0) begin : g_bad_bits
    $error("BITS must divide both DATA_BITS and ECC_BITS");
  end

  logic [1:0]          state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [ECC_BITS-1:0] lfsr, lfsr_n, step_in, step_out;
  logic                valid_n, first_n, last_n;
  logic [BITS-1:0]     data_out_n;
  logic                parity_done;

  // cnt == ECC_BEATS in PARITY means the final parity beat is on data_out
  assign parity_done = (state == S_PARITY) && (cnt == CNT_W'(ECC_BEATS));
  assign ready       = (state == S_IDLE) || parity_done;
  // A new codeword always divides from a clean register
  assign step_in     = (state == S_DATA) ? lfsr : '0;

  bch_lfsr_step #(
    .ECC_BITS (ECC_BITS),
    .BITS     (BITS),
    .GEN      (GEN)
  ) u_step (
    .lfsr_in  (step_in),
    .data     (data_in),
    .lfsr_out (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lfsr     <= '0;
      valid    <= 1'b0;
      first    <= 1'b0;
      last     <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lfsr     <= lfsr_n;
      valid    <= valid_n;
      first    <= first_n;
      last     <= last_n;
      data_out <= data_out_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lfsr_n     = lfsr;
    valid_n    = 1'b0;
    first_n    = 1'b0;
    last_n     = 1'b0;
    data_out_n = data_out;
    case (state)
      S_IDLE: ;
      S_DATA: begin
        if (data_valid) begin
          lfsr_n     = step_out;
          valid_n    = 1'b1;
          data_out_n = data_in;
          if (cnt == CNT_W'(DATA_BEATS - 1)) begin
            state_n = S_PARITY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (!parity_done) begin
          valid_n    = 1'b1;
          data_out_n = lfsr[ECC_BITS-1 -: BITS];
          lfsr_n     = lfsr << BITS;
          last_n     = (cnt == CNT_W'(ECC_BEATS - 1));
          cnt_n      = cnt + 1'b1;
        end else begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    // Start overrides the idle/parity-done transitions and consumes beat 0
    if (ready && start) begin
      lfsr_n     = step_out;
      valid_n    = 1'b1;
      first_n    = 1'b1;
      data_out_n = data_in;
      if (DATA_BEATS == 1) begin
        state_n = S_PARITY;
        cnt_n   = '0;
      end else begin
        state_n = S_DATA;
        cnt_n   = CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bch_encode_stream.sv
// Directed and randomized checks of bch_encode_stream for BCH(15,7), BITS=1,
// against a long-division parity model.
module tb_bch_encode_stream;
  import bch_encode_stream_pkg::*;

  localparam int unsigned G = 32'h1D1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       data_valid = 1'b0;
  logic [0:0] data_in = 1'b0;
  logic       ready, valid, first, last;
  logic [0:0] data_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic d;
    logic f;
    logic l;
    logic r;
    int   c;
  } beat_t;
  beat_t q[$];

  bch_encode_stream #(.P(BCH_SANE), .BITS(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ready      (ready),
    .data_valid (data_valid),
    .data_in    (data_in),
    .valid      (valid),
    .first      (first),
    .last       (last),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid === 1'b1) q.push_back('{data_out[0], first, last, ready, cyc});

  initial begin
    #400000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Remainder of msg(x) * x^8 divided by g(x)
  function automatic logic [7:0] parity_of(input logic [6:0] msg);
    int unsigned r;
    r = 32'({msg, 8'h00});
    for (int b = 14; b >= 8; b--) if (r[b]) r = r ^ (G << (b - 8));
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 200 && ready !== 1'b1; k++) @(negedge clk);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic drive_msg(input logic [6:0] msg, input int gap_at, input int gap_len,
                           input string tag);
    wait_ready(tag);
    start = 1'b1;
    data_valid = 1'($urandom);
    data_in = msg[6];
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 7; i++) begin
      if (i == gap_at) begin
        data_valid = 1'b0;
        data_in = 1'($urandom);
        repeat (gap_len) @(negedge clk);
      end
      data_valid = 1'b1;
      data_in = msg[6 - i];
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic check_cw(input logic [6:0] msg, input int exp_gaps, input string tag,
                          output int fc, output int lc);
    beat_t b;
    logic [14:0] d, fp, lp;
    int c6, c7;
    logic rdy;
    fc = 0;
    lc = 0;
    for (int k = 0; k < 300 && q.size() < 15; k++) @(negedge clk);
    chk({tag, "_len"}, 32'(q.size() >= 15), 32'd1);
    if (q.size() < 15) begin
      q.delete();
      return;
    end
    d = '0; fp = '0; lp = '0; c6 = 0; c7 = 0; rdy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      b = q.pop_front();
      d = {d[13:0], b.d};
      fp = {fp[13:0], b.f};
      lp = {lp[13:0], b.l};
      if (i == 0) fc = b.c;
      if (i == 6) c6 = b.c;
      if (i == 7) c7 = b.c;
      if (i == 14) begin
        lc = b.c;
        rdy = b.r;
      end
    end
    chk({tag, "_data"}, 32'(d), 32'({msg, parity_of(msg)}));
    chk({tag, "_first"}, 32'(fp), 32'h4000);
    chk({tag, "_last"}, 32'(lp), 32'h0001);
    chk({tag, "_gaps"}, 32'(c6 - fc - 6), 32'(exp_gaps));
    chk({tag, "_nostall"}, 32'(lc - c7), 32'd7);
    chk({tag, "_ready_on_last"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    int fa, la, fb, lb;
    logic [6:0] m;
    int ga, gl;

    // reset state
    #12;
    chk("rst_outputs", 32'({valid, first, last, data_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);

    // all-zero message
    drive_msg(7'h00, 0, 0, "zero");
    check_cw(7'h00, 0, "zero", fa, la);

    // single-one message
    drive_msg(7'h01, 0, 0, "one");
    check_cw(7'h01, 0, "one", fa, la);
    chk("one_parity_model", 32'(parity_of(7'h01)), 32'hD1);

    // all-ones message
    drive_msg(7'h7F, 0, 0, "ones");
    check_cw(7'h7F, 0, "ones", fa, la);

    // three-cycle data_valid gap after beat 3
    drive_msg(7'h01, 4, 3, "gap");
    check_cw(7'h01, 3, "gap", fa, la);

    // back-to-back codewords
    drive_msg(7'h01, 0, 0, "b2b_a");
    drive_msg(7'h7F, 0, 0, "b2b_b");
    check_cw(7'h01, 0, "b2b_a", fa, la);
    check_cw(7'h7F, 0, "b2b_b", fb, lb);
    chk("b2b_adjacent", 32'(fb - la), 32'd1);

    // start/data_valid while busy must be ignored
    drive_msg(7'h2A, 0, 0, "busy");
    chk("busy_not_ready", 32'(ready), 32'd0);
    start = 1'b1;
    data_valid = 1'b1;
    data_in = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    data_valid = 1'b0;
    check_cw(7'h2A, 0, "busy", fa, la);
    repeat (4) @(negedge clk);
    chk("busy_no_extra", 32'(q.size()), 32'd0);

    // randomized messages and gaps
    for (int r = 0; r < 6; r++) begin
      m = 7'($urandom);
      ga = int'($urandom_range(1, 6));
      gl = int'($urandom_range(0, 3));
      drive_msg(m, ga, gl, "rand");
      check_cw(m, gl, "rand", fa, la);
    end

    // reset during message beat 4
    wait_ready("mid");
    start = 1'b1;
    data_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    data_valid = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("mid_pre_valid", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'({valid, first, last, data_out}), 32'd0);
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    chk("mid_ready", 32'(ready), 32'd1);
    drive_msg(7'h01, 0, 0, "post");
    check_cw(7'h01, 0, "post", fa, la);
    repeat (4) @(negedge clk);
    chk("post_no_extra", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
